hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the ID stage: load-use stalls, ID-stage forwarding selects, branch/jump redirect
//   and IF/ID flush, plus a debug halt/drain/resume FSM.
//  Drives PC write-enable, IF/ID write and flush, ctrl_sel (bubble insert) and forward_data_reg1/2 into instruction_decode.
// PARAMETERS
//  DRAIN_CYCLES  3   bubble cycles issued after halt entry before halted=1 (1..15)
//  CNT_W         32  width of perf counters (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk               in   1  clock, all state on rising edge
//  reset             in   1  synchronous, active-high
//  IF_ID_rs1/rs2     in   5  source regs of instruction in ID
//  id_use_rs1/rs2    in   1  ID instruction actually reads rs1/rs2
//  id_branch         in   1  ID holds conditional branch (beq)
//  id_jump           in   1  ID holds jal
//  br_eq             in   1  ID-stage compare result
//  ID_EX_rd          in   5  dest of instruction in EX
//  ID_EX_reg_write   in   1  EX instruction writes rd
//  ID_EX_mem_read    in   1  EX instruction is a load
//  EX_MEM_rd         in   5  dest of instruction in MEM
//  EX_MEM_reg_write  in   1  MEM instruction writes rd
//  halt_req          in   1  debug halt request, level
//  resume_req        in   1  debug resume, single-cycle pulse
//  pc_write          out  1  PC register load enable
//  pc_sel            out  1  1 = next PC is pc_branch, 0 = PC+4
//  IF_ID_write       out  1  IF/ID register load enable
//  IF_ID_flush       out  1  IF/ID loads NOP at this edge
//  ctrl_sel          out  1  0 = zero control into ID/EX (bubble)
//  forward_data_reg1 out  2  00 regfile, 01 EX alu_out, 10 MEM result
//  forward_data_reg2 out  2  same encoding for rs2
//  halted            out  1  FSM in HALTED
// BEHAVIOUR
//  Reset is synchronous and active-high. While reset=1: pc_write=0, pc_sel=0, IF_ID_write=0, IF_ID_flush=1,
//   ctrl_sel=0, fwd=00, halted=0.
//  Reset dominates all inputs mid-operation. The state after the reset edge is RUN, with the drain counter at 0.
//  Forwarding (combinational, every state, per rsN):
//   - rsN==0 or !id_use_rsN -> 00.
//   - Else EX match (ID_EX_reg_write, ID_EX_rd==rsN, !ID_EX_mem_read) -> 01.
//   - Else MEM match (EX_MEM_reg_write, EX_MEM_rd==rsN) -> 10.
//   - Else 00. EX has priority over MEM.
//  ld_haz = ID_EX_mem_read & ID_EX_reg_write & ID_EX_rd!=0 & matches a used rsN.
//  redirect = !ld_haz & (id_jump | id_branch&br_eq).
//  RUN:
//   - ld_haz: pc_write=0, IF_ID_write=0, ctrl_sel=0, flush=0. One cycle only; next cycle the load is in MEM -> fwd 10.
//   - redirect: pc_write=1, pc_sel=1, IF_ID_flush=1, ctrl_sel=1. Taken penalty is exactly 1 bubble.
//   - Otherwise: pc_write=1, IF_ID_write=1, ctrl_sel=1, pc_sel=0, flush=0.
//   - halt_req & !ld_haz: ID instruction issues (ctrl_sel=1) and IF_ID_flush=1.
//     pc_write=redirect, so PC holds the squashed fetch address, or the target on redirect. Next state is DRAIN, cnt=DRAIN_CYCLES-1.
//   - halt_req & ld_haz: stall first; halt is taken on a later RUN cycle.
//  DRAIN:
//   - Outputs: pc_write=0, IF_ID_write=0, ctrl_sel=0, flush=0.
//   - cnt==0 -> HALTED, else decrement.
//   - halt_req drop and resume_req are ignored.
//  HALTED:
//   - Outputs as DRAIN, halted=1.
//   - resume_req -> RUN at the next edge. halt_req still high is ignored until after resume.
//  Invariant (assertion): no two consecutive ld_haz stall cycles.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds ports stall_count and flush_count (out, CNT_W).
//   - stall_count increments on each ld_haz stall cycle in RUN.
//   - flush_count increments on each IF_ID_flush cycle outside reset.
//   - Both saturate at all-ones and clear on reset.
//  HAZARD_PERF_CNT_EN undefined: those ports and registers do not exist.
// STRUCTURE
//  riscv_pkg:
//   - hz_state_e {HZ_RUN, HZ_DRAIN, HZ_HALTED}.
//   - fwd_sel_e {FWD_REG=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10}.
//  Sub-module forward_unit: combinational source-select for one operand, instantiated for rs1 and rs2.
//  Top holds the FSM, drain counter and perf counters.
// TESTING
//  1. lw x5 in EX, ID add x6,x5,x1 -> 1 cycle pc_write=0, ctrl_sel=0; next cycle fwd1=10, pc_write=1.
//  2. EX add x3 (wr), MEM x3 (wr), ID rs1=x3 -> fwd1=01. ID rs2=x0 with EX rd=0 wr=1 -> fwd2=00.
//  3. beq with br_eq=1 -> pc_sel=1, IF_ID_flush=1 same cycle. With ld_haz also true -> no redirect, stall only.
//  4. halt_req during RUN, DRAIN_CYCLES=3 -> flush, then 3 DRAIN cycles, halted=1 on 5th cycle.
//     resume_req -> pc_write=1 next cycle, fetch resumes at held PC.
//  5. reset pulsed mid-DRAIN -> next cycle RUN, halted=0. Perf counters = 0 when HAZARD_PERF_CNT_EN is defined.
//  6. HAZARD_PERF_CNT_EN, CNT_W=4, 17 stalls -> stall_count=15 (saturated). Build without macro -> elaborates, no count ports.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the ID-stage hazard controller.
package riscv_pkg;
    typedef enum logic [1:0] {HZ_RUN, HZ_DRAIN, HZ_HALTED} hz_state_e;
    typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: operand source select for one ID-stage register read.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       use_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_wr_i,
    input  logic       ex_load_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_wr_i,
    output logic [1:0] sel_o
);
    // A load in EX has no data yet; the stall lets it forward from MEM next cycle.
    always_comb
        sel_o = (rs_i == 5'd0 || !use_i)                       ? FWD_REG :
                (ex_wr_i && ex_rd_i == rs_i && !ex_load_i)     ? FWD_EX  :
                (mem_wr_i && mem_rd_i == rs_i)                 ? FWD_MEM : FWD_REG;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, forwarding, redirect/flush and debug halt/drain/resume.
// Optional perf counters stall_count/flush_count under HAZARD_PERF_CNT_EN.
module hazard_controller
    import riscv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IF_ID_rs1,
    input  logic [4:0] IF_ID_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_branch,
    input  logic       id_jump,
    input  logic       br_eq,
    input  logic [4:0] ID_EX_rd,
    input  logic       ID_EX_reg_write,
    input  logic       ID_EX_mem_read,
    input  logic [4:0] EX_MEM_rd,
    input  logic       EX_MEM_reg_write,
    input  logic       halt_req,
    input  logic       resume_req,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       IF_ID_write,
    output logic       IF_ID_flush,
    output logic       ctrl_sel,
    output logic [1:0] forward_data_reg1,
    output logic [1:0] forward_data_reg2,
    output logic       halted
`ifdef HAZARD_PERF_CNT_EN
    , output logic [CNT_W-1:0] stall_count
    , output logic [CNT_W-1:0] flush_count
`endif
);
    hz_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] f1, f2;
    logic       ld_haz, redirect, stall, stall_q;

    forward_unit u_fwd1 (.rs_i(IF_ID_rs1), .use_i(id_use_rs1), .ex_rd_i(ID_EX_rd), .ex_wr_i(ID_EX_reg_write),
                         .ex_load_i(ID_EX_mem_read), .mem_rd_i(EX_MEM_rd), .mem_wr_i(EX_MEM_reg_write), .sel_o(f1));
    forward_unit u_fwd2 (.rs_i(IF_ID_rs2), .use_i(id_use_rs2), .ex_rd_i(ID_EX_rd), .ex_wr_i(ID_EX_reg_write),
                         .ex_load_i(ID_EX_mem_read), .mem_rd_i(EX_MEM_rd), .mem_wr_i(EX_MEM_reg_write), .sel_o(f2));

    assign ld_haz   = ID_EX_mem_read && ID_EX_reg_write && ID_EX_rd != 5'd0 &&
                      ((id_use_rs1 && IF_ID_rs1 == ID_EX_rd) || (id_use_rs2 && IF_ID_rs2 == ID_EX_rd));
    assign redirect = !ld_haz && (id_jump || (id_branch && br_eq));
    assign stall    = !reset && state_q == HZ_RUN && ld_haz;
    assign forward_data_reg1 = reset ? FWD_REG : f1;
    assign forward_data_reg2 = reset ? FWD_REG : f2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= 4'd0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall;
            assert (!(stall && stall_q));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HZ_RUN:    if (halt_req && !ld_haz) begin
                           state_d = HZ_DRAIN;
                           cnt_d   = 4'(DRAIN_CYCLES - 1);
                       end
            HZ_DRAIN:  if (cnt_q == 4'd0) state_d = HZ_HALTED;
                       else cnt_d = cnt_q - 4'd1;
            HZ_HALTED: if (resume_req) state_d = HZ_RUN;
            default:   state_d = HZ_RUN;
        endcase
    end

    // On halt entry the ID instruction issues but the fetched one is squashed, so PC holds unless redirecting.
    always_comb begin
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = reset;
        ctrl_sel    = 1'b0;
        halted      = !reset && state_q == HZ_HALTED;
        if (!reset && state_q == HZ_RUN && !ld_haz) begin
            pc_write    = !halt_req || redirect;
            pc_sel      = redirect;
            IF_ID_write = 1'b1;
            IF_ID_flush = redirect || halt_req;
            ctrl_sel    = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
            if (IF_ID_flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table vectors, halt/reset sequences and random stimulus vs a reference model.
module tb_hazard_controller;
    localparam int DRAIN = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] stall_count, flush_count;
`endif
    typedef struct {
        logic rst; logic [4:0] rs1, rs2; logic u1, u2, br, jmp, eq;
        logic [4:0] exrd; logic exwr, exmr; logic [4:0] memrd; logic memwr, halt, resume;
    } in_t;
    typedef struct { string name; in_t in; logic [9:0] exp; } vec_t;

    logic clk = 0, reset;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
    logic id_use_rs1, id_use_rs2, id_branch, id_jump, br_eq, ID_EX_reg_write, ID_EX_mem_read;
    logic EX_MEM_reg_write, halt_req, resume_req;
    logic pc_write, pc_sel, IF_ID_write, IF_ID_flush, ctrl_sel, halted;
    logic [1:0] forward_data_reg1, forward_data_reg2;
    int checks = 0, failures = 0;
    int m_st = 0, m_left = 0;
    longint m_stalls = 0, m_flushes = 0;
    logic prev_stall = 0;

    always #5 clk = ~clk;

    hazard_controller #(.DRAIN_CYCLES(DRAIN)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch), .id_jump(id_jump),
        .br_eq(br_eq), .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write), .halt_req(halt_req), .resume_req(resume_req),
        .pc_write(pc_write), .pc_sel(pc_sel), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ctrl_sel(ctrl_sel), .forward_data_reg1(forward_data_reg1), .forward_data_reg2(forward_data_reg2),
        .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    function automatic logic [1:0] ref_fwd(logic [4:0] rs, logic u, in_t v);
        if (rs == 0 || !u) return 2'b00;
        if (v.exwr && v.exrd == rs && !v.exmr) return 2'b01;
        if (v.memwr && v.memrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic ref_ld(in_t v);
        return v.exmr && v.exwr && v.exrd != 0 && ((v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd));
    endfunction

    // Output vector: {pc_write, pc_sel, IF_ID_write, IF_ID_flush, ctrl_sel, fwd1, fwd2, halted}
    function automatic logic [9:0] ref_out(in_t v);
        logic ld, rd;
        logic [1:0] a, b;
        ld = ref_ld(v);
        rd = !ld && (v.jmp || (v.br && v.eq));
        a  = ref_fwd(v.rs1, v.u1, v);
        b  = ref_fwd(v.rs2, v.u2, v);
        if (v.rst) return 10'b0001000000;
        if (m_st != 0) return {5'b0, a, b, m_st == 2};
        if (ld) return {5'b0, a, b, 1'b0};
        return {!v.halt || rd, rd, 1'b1, rd || v.halt, 1'b1, a, b, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input in_t v, input string nm, input logic has_exp = 0, input logic [9:0] exp = '0);
        logic [9:0] m, act;
        @(negedge clk);
        reset = v.rst; IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        id_branch = v.br; id_jump = v.jmp; br_eq = v.eq; ID_EX_rd = v.exrd; ID_EX_reg_write = v.exwr;
        ID_EX_mem_read = v.exmr; EX_MEM_rd = v.memrd; EX_MEM_reg_write = v.memwr;
        halt_req = v.halt; resume_req = v.resume;
        #2;
        m   = ref_out(v);
        act = {pc_write, pc_sel, IF_ID_write, IF_ID_flush, ctrl_sel, forward_data_reg1, forward_data_reg2, halted};
        if (has_exp) chk(nm, act, exp);
        chk({nm, "_model"}, act, m);
`ifdef HAZARD_PERF_CNT_EN
        chk({nm, "_stall_cnt"}, stall_count, m_stalls);
        chk({nm, "_flush_cnt"}, flush_count, m_flushes);
`endif
        prev_stall = !v.rst && m_st == 0 && ref_ld(v);
        @(posedge clk);
        if (v.rst) begin
            m_st = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            if (prev_stall && m_stalls < (64'd1 << CW) - 1) m_stalls++;
            if (m[6] && m_flushes < (64'd1 << CW) - 1) m_flushes++;
`endif
            if (m_st == 0 && v.halt && !ref_ld(v)) begin
                m_st = 1; m_left = DRAIN;
            end else if (m_st == 1) begin
                m_left--;
                if (m_left == 0) m_st = 2;
            end else if (m_st == 2 && v.resume) m_st = 0;
        end
    endtask

    in_t idle, v, rv;
    vec_t tbl[$];

    initial begin
        idle = '{rst: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, br: 0, jmp: 0, eq: 0,
                 exrd: 0, exwr: 0, exmr: 0, memrd: 0, memwr: 0, halt: 0, resume: 0};
        v = idle; v.rst = 1;
        tbl.push_back('{"reset", v, 10'b0001000000});
        v = idle; v.rs1 = 5; v.u1 = 1; v.rs2 = 1; v.u2 = 1; v.exrd = 5; v.exwr = 1; v.exmr = 1;
        tbl.push_back('{"load_use_stall", v, 10'b0000000000});
        v = idle; v.rs1 = 5; v.u1 = 1; v.rs2 = 1; v.u2 = 1; v.memrd = 5; v.memwr = 1;
        tbl.push_back('{"load_fwd_mem", v, 10'b1010110000});
        v = idle; v.rs1 = 3; v.u1 = 1; v.u2 = 1; v.exrd = 3; v.exwr = 1; v.memrd = 3; v.memwr = 1;
        tbl.push_back('{"ex_over_mem", v, 10'b1010101000});
        v = idle; v.rs1 = 7; v.u2 = 1; v.exwr = 1; v.memrd = 7; v.memwr = 1;
        tbl.push_back('{"x0_and_unused", v, 10'b1010100000});
        v = idle; v.br = 1; v.eq = 1;
        tbl.push_back('{"beq_taken", v, 10'b1111100000});
        v = idle; v.br = 1; v.eq = 1; v.rs1 = 4; v.u1 = 1; v.exrd = 4; v.exwr = 1; v.exmr = 1;
        tbl.push_back('{"beq_with_ld_haz", v, 10'b0000000000});
        v = idle; v.jmp = 1;
        tbl.push_back('{"jal", v, 10'b1111100000});
        v = idle; v.br = 1;
        tbl.push_back('{"beq_not_taken", v, 10'b1010100000});
        v = idle; v.rs2 = 9; v.u2 = 1; v.exrd = 9; v.memrd = 9; v.memwr = 1;
        tbl.push_back('{"rs2_mem_fwd", v, 10'b1010100100});
        v = idle; v.rs2 = 6; v.exrd = 6; v.exwr = 1; v.exmr = 1;
        tbl.push_back('{"load_rs2_unused", v, 10'b1010100000});
        foreach (tbl[i]) step(tbl[i].in, tbl[i].name, 1, tbl[i].exp);

        v = idle; v.rst = 1; step(v, "halt_pre_reset");
        v = idle; v.halt = 1;
        step(v, "halt_entry", 1, 10'b0011100000);
        step(v, "drain1", 1, 10'b0);
        v.resume = 1; step(v, "drain2_resume_ignored", 1, 10'b0);
        v.resume = 0; v.halt = 0; step(v, "drain3_halt_drop", 1, 10'b0);
        v.halt = 1; step(v, "halted_5th", 1, 10'b0000000001);
        step(v, "halted_hold", 1, 10'b0000000001);
        v.resume = 1; step(v, "resume_cycle", 1, 10'b0000000001);
        step(idle, "resume_fetch", 1, 10'b1010100000);

        v = idle; v.halt = 1; step(v, "halt_entry2", 1, 10'b0011100000);
        step(v, "drain_before_reset", 1, 10'b0);
        v.rst = 1; step(v, "reset_mid_drain", 1, 10'b0001000000);
        step(idle, "run_after_reset", 1, 10'b1010100000);

`ifdef HAZARD_PERF_CNT_EN
        v = idle; v.rst = 1; step(v, "sat_reset");
        chk("cnt_cleared", {stall_count, flush_count}, 0);
        v = idle; v.rs1 = 2; v.u1 = 1; v.exrd = 2; v.exwr = 1; v.exmr = 1;
        for (int i = 0; i < 17; i++) begin
            step(v, "sat_stall");
            step(idle, "sat_gap");
        end
        chk("stall_saturated", stall_count, 15);
`endif

        for (int i = 0; i < 600; i++) begin
            rv.rst = $urandom_range(0, 49) == 0;
            rv.rs1 = 5'($urandom_range(0, 3)); rv.rs2 = 5'($urandom_range(0, 3));
            rv.u1 = 1'($urandom); rv.u2 = 1'($urandom); rv.br = 1'($urandom);
            rv.jmp = $urandom_range(0, 3) == 0; rv.eq = 1'($urandom);
            rv.exrd = 5'($urandom_range(0, 3)); rv.exwr = 1'($urandom); rv.exmr = 1'($urandom);
            rv.memrd = 5'($urandom_range(0, 3)); rv.memwr = 1'($urandom);
            rv.halt = $urandom_range(0, 9) == 0; rv.resume = $urandom_range(0, 5) == 0;
            if (prev_stall) rv.exmr = 0;
            step(rv, "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
